// File: rtl/tm1638_graphics_renderer.sv
// tm1638_graphics_renderer
//   On-screen TM1638 emulator. Holds live digit segment registers written by lab
//   logic and latches them, together with the LED row, into shadow registers once
//   per frame so that the picture never tears. Key presses are stretched over a
//   few frames, selected digits blink, and the panel is rendered through a
//   two-stage pixel pipeline into 1-bit RGB.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   hgfedcba, digit   segment pattern (bit0=a .. bit7=dp) and per-digit write strobe
//   ledr, keys        LED states, raw key states (1 = pressed)
//   blink_mask        1 = digit blinks
//   display_on        0 = black panel
//   frame_start       one-cycle pulse at the start of each frame
//   x, y              current pixel position
//   red, green, blue  registered pixel colour, valid two clocks after x/y
module tm1638_graphics_renderer #(
    parameter int unsigned w_digit         = 8,
    parameter int unsigned w_keys          = 8,
    parameter int unsigned screen_width    = 640,
    parameter int unsigned screen_height   = 480,
    parameter int unsigned blink_frames    = 32,
    parameter int unsigned key_hold_frames = 4,
    parameter int unsigned w_x             = $clog2(screen_width),
    parameter int unsigned w_y             = $clog2(screen_height)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         hgfedcba,
    input  logic [w_digit-1:0] digit,
    input  logic [w_digit-1:0] ledr,
    input  logic [w_keys-1:0]  keys,
    input  logic [w_digit-1:0] blink_mask,
    input  logic               display_on,
    input  logic               frame_start,
    input  logic [w_x-1:0]     x,
    input  logic [w_y-1:0]     y,
    output logic               red,
    output logic               green,
    output logic               blue
);

    localparam int unsigned cellsx = 8 * w_digit + 3;
    localparam int unsigned cellsy = 16;
    localparam int unsigned s      = $clog2(screen_width / cellsx) - 1;
    localparam int unsigned offx   = (screen_width - (cellsx << s)) / 2;
    localparam int unsigned offy   = (screen_height - (cellsy << s)) / 2;
    localparam int unsigned w_f    = $clog2(blink_frames + 1);
    localparam int unsigned w_k    = $clog2(key_hold_frames + 1);
    localparam int          nd     = int'(w_digit);
    localparam int          nk     = int'(w_keys);

    localparam logic [w_x-1:0] offx_v    = w_x'(offx);
    localparam logic [w_y-1:0] offy_v    = w_y'(offy);
    localparam logic [w_f-1:0] fcnt_last = w_f'(blink_frames - 1);
    localparam logic [w_f-1:0] fcnt_one  = w_f'(1);
    localparam logic [w_k-1:0] hold_v    = w_k'(key_hold_frames);
    localparam logic [w_k-1:0] hold_one  = w_k'(1);

    logic [w_digit-1:0][7:0] live_q;
    logic [w_digit-1:0][7:0] shadow_q;
    logic [w_digit-1:0]      led_sh_q;
    logic [w_k-1:0]          cnt_q [w_keys];
    logic [w_keys-1:0]       key_shown;
    logic [w_f-1:0]          fcnt_q;
    logic                    phase_q;
    // Cleared by reset, set by the first frame_start: keeps the panel black
    // until a full frame has been latched, so no stale or partial state shows.
    logic                    frame_valid_q;

    logic [w_x-1:0] xrel;
    logic [w_y-1:0] yrel;
    logic [w_x-1:0] cx_q;
    logic [w_y-1:0] cy_q;
    logic [w_x:0]   dx;
    logic [w_y:0]   dy;
    logic [2:0]     rgb_d;
    logic [2:0]     rgb_q;

    int         dxi;
    int         dyi;
    int         pos;
    int         col;
    logic [7:0] pat;
    logic       led;
    logic       key;
    logic       seg;

    // Live registers, frame latch and blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q        <= '0;
            shadow_q      <= '0;
            led_sh_q      <= '0;
            fcnt_q        <= '0;
            phase_q       <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < nd; i++) begin
                if (digit[i]) live_q[i] <= hgfedcba;
            end
            if (frame_start) begin
                // Non-blocking read of live_q: a coinciding write shows next frame
                shadow_q      <= live_q;
                led_sh_q      <= ledr;
                frame_valid_q <= 1'b1;
                if (fcnt_q == fcnt_last) begin
                    fcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    fcnt_q <= fcnt_q + fcnt_one;
                end
            end
        end
    end

    // Key stretch counters
    always_ff @(posedge clk) begin
        for (int k = 0; k < nk; k++) begin
            if (rst) begin
                cnt_q[k] <= '0;
            end else if (keys[k]) begin
                cnt_q[k] <= hold_v;
            end else if (frame_start && (cnt_q[k] != '0)) begin
                cnt_q[k] <= cnt_q[k] - hold_one;
            end
        end
    end

    always_comb begin
        key_shown = '0;
        for (int k = 0; k < nk; k++) begin
            key_shown[k] = keys[k] | (cnt_q[k] != '0);
        end
    end

    // S1: panel-relative cell coordinates; pixels left/above the panel wrap large
    assign xrel = x - offx_v;
    assign yrel = y - offy_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= xrel >> s;
            cy_q <= yrel >> s;
        end
    end

    // Groups of four cells become wide/thin/wide/thin columns (3 cells, 1 cell)
    assign dx = ({1'b0, cx_q} >> 2) + (({1'b0, cx_q} + {{w_x{1'b0}}, 1'b1}) >> 2);
    assign dy = ({1'b0, cy_q} >> 2) + (({1'b0, cy_q} + {{w_y{1'b0}}, 1'b1}) >> 2);

    // S2: decode the cell into LED / separator / key / segment and colour it
    always_comb begin
        dxi = int'(dx);
        dyi = int'(dy);
        pos = (dxi - 1) / 4;
        col = dxi - 4 * pos;
        pat = 8'h00;
        led = 1'b0;
        key = 1'b0;
        for (int i = 0; i < nd; i++) begin
            if (pos == nd - 1 - i) begin
                pat = (phase_q && blink_mask[i]) ? 8'h00 : shadow_q[i];
                led = led_sh_q[i];
            end
        end
        for (int k = 0; k < nk; k++) begin
            if (pos == nd - 1 - k) key = key_shown[k];
        end
        seg = ((dyi == 3) && (col == 2) && pat[0]) ||
              ((dyi == 4) && (col == 1) && pat[5]) ||
              ((dyi == 4) && (col == 3) && pat[1]) ||
              ((dyi == 5) && (col == 2) && pat[6]) ||
              ((dyi == 6) && (col == 1) && pat[4]) ||
              ((dyi == 6) && (col == 3) && pat[2]) ||
              ((dyi == 7) && (col == 2) && pat[3]) ||
              ((dyi == 7) && (col == 4) && pat[7]);
        rgb_d = 3'b000;
        if (frame_valid_q && display_on && (dxi >= 1) && (dxi <= 4 * nd) && (dyi < 8)) begin
            case (dyi)
                0:       if ((col <= 3) && led) rgb_d = 3'b100;
                1:       if (dxi <= 4 * nd - 1) rgb_d = 3'b111;
                2:       if ((col <= 3) && key) rgb_d = 3'b110;
                default: if (seg) rgb_d = 3'b111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rgb_q <= 3'b000;
        else     rgb_q <= rgb_d;
    end

    assign {red, green, blue} = rgb_q;

endmodule
